// File: rtl/bus_xbar_nm.sv
// bus_xbar_nm: N-host x M-device crossbar for the req/gnt/rvalid memory bus.
// Hosts: req/addr/we/be/wdata in, gnt/rvalid/rdata/err out.
// Devices: req/addr/we/be/wdata out, gnt/rvalid/rdata/err in.
// Per-device round-robin arbitration, in-order id FIFOs route responses back,
// unmapped addresses get a one-cycle error response.
module bus_xbar_nm #(
   parameter int unsigned NrHosts        = 2,
   parameter int unsigned NrDevices      = 4,
   parameter int unsigned AW             = 32,
   parameter int unsigned DW             = 32,
   parameter int unsigned DevOutstanding = 2,
   parameter logic [NrDevices*AW-1:0] AddrBase = '0,
   parameter logic [NrDevices*AW-1:0] AddrMask = '0
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [NrHosts-1:0]               host_req_i,
   input  logic [NrHosts-1:0][AW-1:0]       host_addr_i,
   input  logic [NrHosts-1:0]               host_we_i,
   input  logic [NrHosts-1:0][DW/8-1:0]     host_be_i,
   input  logic [NrHosts-1:0][DW-1:0]       host_wdata_i,
   output logic [NrHosts-1:0]               host_gnt_o,
   output logic [NrHosts-1:0]               host_rvalid_o,
   output logic [NrHosts-1:0][DW-1:0]       host_rdata_o,
   output logic [NrHosts-1:0]               host_err_o,
   output logic [NrDevices-1:0]             dev_req_o,
   output logic [NrDevices-1:0][AW-1:0]     dev_addr_o,
   output logic [NrDevices-1:0]             dev_we_o,
   output logic [NrDevices-1:0][DW/8-1:0]   dev_be_o,
   output logic [NrDevices-1:0][DW-1:0]     dev_wdata_o,
   input  logic [NrDevices-1:0]             dev_gnt_i,
   input  logic [NrDevices-1:0]             dev_rvalid_i,
   input  logic [NrDevices-1:0][DW-1:0]     dev_rdata_i,
   input  logic [NrDevices-1:0]             dev_err_i
);

   localparam int unsigned IdW  = (NrHosts > 1) ? $clog2(NrHosts) : 1;
   localparam int unsigned PtrW = (DevOutstanding > 1) ? $clog2(DevOutstanding) : 1;
   localparam int unsigned CntW = $clog2(DevOutstanding + 1);

   typedef logic [IdW-1:0]  id_t;
   typedef logic [PtrW-1:0] ptr_t;

   logic [NrHosts-1:0] busy_q, busy_d, err_pend_q, err_pend_d;
   logic [NrDevices-1:0] lock_q, lock_d;
   id_t  [NrDevices-1:0] win_q, win_d, rr_q, rr_d;
   id_t  [NrDevices-1:0][DevOutstanding-1:0] fifo_q, fifo_d;
   ptr_t [NrDevices-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [NrDevices-1:0][CntW-1:0] cnt_q, cnt_d;

   logic [NrHosts-1:0]                 hit, rsp_v, rsp_err, busy_eff, gnt;
   logic [NrHosts-1:0][NrDevices-1:0]  sel;
   logic [NrHosts-1:0][DW-1:0]         rsp_data;
   logic [NrDevices-1:0]               pop, dreq, wv;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(DevOutstanding - 1)) ? '0 : p + 1'b1;
   endfunction

   // Address decode, lowest matching device index wins.
   always_comb begin
      hit = '0;
      sel = '0;
      for (int h = 0; h < int'(NrHosts); h++) begin
         for (int d = 0; d < int'(NrDevices); d++) begin
            if (!hit[h] && ((host_addr_i[h] & AddrMask[d*AW +: AW])
                            == AddrBase[d*AW +: AW])) begin
               sel[h][d] = 1'b1;
               hit[h]    = 1'b1;
            end
         end
      end
   end

   // Response routing: FIFO head of a responding device names the host.
   always_comb begin
      pop      = '0;
      rsp_v    = '0;
      rsp_err  = '0;
      rsp_data = '0;
      for (int d = 0; d < int'(NrDevices); d++) begin
         pop[d] = dev_rvalid_i[d] && (cnt_q[d] != '0);
         for (int h = 0; h < int'(NrHosts); h++) begin
            if (pop[d] && fifo_q[d][rptr_q[d]] == id_t'(h)) begin
               rsp_v[h]    = 1'b1;
               rsp_data[h] = dev_rdata_i[d];
               rsp_err[h]  = dev_err_i[d];
            end
         end
      end
      for (int h = 0; h < int'(NrHosts); h++) begin
         if (err_pend_q[h]) begin
            rsp_v[h]    = 1'b1;
            rsp_err[h]  = 1'b1;
            rsp_data[h] = '0;
         end
      end
   end

   // Arbitration, FIFO bookkeeping and busy tracking.
   always_comb begin
      int   idx;
      logic full;
      logic fire;
      idx        = 0;
      full       = 1'b0;
      fire       = 1'b0;
      // A response this cycle frees the host for a new grant this cycle.
      busy_eff   = busy_q & ~rsp_v;
      gnt        = '0;
      dreq       = '0;
      wv         = '0;
      win_d      = '0;
      lock_d     = '0;
      rr_d       = rr_q;
      fifo_d     = fifo_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      cnt_d      = cnt_q;
      err_pend_d = '0;
      for (int d = 0; d < int'(NrDevices); d++) begin
         if (lock_q[d]) begin
            win_d[d] = win_q[d];
            wv[d]    = 1'b1;
         end else begin
            for (int i = 0; i < int'(NrHosts); i++) begin
               idx = (int'(rr_q[d]) + i) % int'(NrHosts);
               if (!wv[d] && host_req_i[idx] && sel[idx][d] && !busy_eff[idx]) begin
                  win_d[d] = id_t'(idx);
                  wv[d]    = 1'b1;
               end
            end
         end
         // A pop this cycle makes room for a push in the same cycle.
         full      = (cnt_q[d] == CntW'(DevOutstanding)) && !pop[d];
         dreq[d]   = rst_ni && wv[d] && !full;
         fire      = dreq[d] && dev_gnt_i[d];
         lock_d[d] = wv[d] && !fire;
         if (fire) begin
            gnt[win_d[d]]              = 1'b1;
            rr_d[d]                    = id_t'((int'(win_d[d]) + 1) % int'(NrHosts));
            fifo_d[d][wptr_q[d]]       = win_d[d];
            wptr_d[d]                  = ptr_inc(wptr_q[d]);
         end
         if (pop[d]) begin
            rptr_d[d] = ptr_inc(rptr_q[d]);
         end
         cnt_d[d] = cnt_q[d] + CntW'(fire) - CntW'(pop[d]);
      end
      for (int h = 0; h < int'(NrHosts); h++) begin
         err_pend_d[h] = rst_ni && host_req_i[h] && !hit[h] && !busy_eff[h];
         if (err_pend_d[h]) begin
            gnt[h] = 1'b1;
         end
      end
      busy_d = busy_eff | gnt;
   end

   always_comb begin
      host_gnt_o    = '0;
      host_rvalid_o = '0;
      host_rdata_o  = '0;
      host_err_o    = '0;
      dev_req_o     = '0;
      dev_addr_o    = '0;
      dev_we_o      = '0;
      dev_be_o      = '0;
      dev_wdata_o   = '0;
      if (rst_ni) begin
         host_gnt_o    = gnt;
         host_rvalid_o = rsp_v;
         host_rdata_o  = rsp_data;
         host_err_o    = rsp_err;
         dev_req_o     = dreq;
         for (int d = 0; d < int'(NrDevices); d++) begin
            if (dreq[d]) begin
               dev_addr_o[d]  = host_addr_i[win_d[d]];
               dev_we_o[d]    = host_we_i[win_d[d]];
               dev_be_o[d]    = host_be_i[win_d[d]];
               dev_wdata_o[d] = host_wdata_i[win_d[d]];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         busy_q     <= '0;
         err_pend_q <= '0;
         lock_q     <= '0;
         win_q      <= '0;
         rr_q       <= '0;
         fifo_q     <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
      end else begin
         busy_q     <= busy_d;
         err_pend_q <= err_pend_d;
         lock_q     <= lock_d;
         win_q      <= win_d;
         rr_q       <= rr_d;
         fifo_q     <= fifo_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         cnt_q      <= cnt_d;
      end
   end

   // A response with nothing outstanding is dropped.
   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         for (int d = 0; d < int'(NrDevices); d++) begin
            assert (!(dev_rvalid_i[d] && cnt_q[d] == '0))
               else $warning("bus_xbar_nm: stray response on device %0d dropped", d);
         end
      end
   end

endmodule

// File: tb/tb_bus_xbar_nm.sv
// tb_bus_xbar_nm: directed checks of bus_xbar_nm with 3 hosts, 4 devices.
// RAM at 0x0010_0000/0xFFF0_0000; DevOutstanding = 2.
module tb_bus_xbar_nm;

   localparam int NH = 3;
   localparam int ND = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam logic [ND*AW-1:0] BASE =
      {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0010_0000};
   localparam logic [ND*AW-1:0] MASK =
      {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_FC00, 32'hFFF0_0000};

   logic clk = 1'b0;
   logic rst_n;
   logic [NH-1:0]            host_req, host_we, host_gnt, host_rvalid, host_err;
   logic [NH-1:0][AW-1:0]    host_addr;
   logic [NH-1:0][DW/8-1:0]  host_be;
   logic [NH-1:0][DW-1:0]    host_wdata, host_rdata;
   logic [ND-1:0]            dev_req, dev_we, dev_gnt, dev_rvalid, dev_err;
   logic [ND-1:0][AW-1:0]    dev_addr;
   logic [ND-1:0][DW/8-1:0]  dev_be;
   logic [ND-1:0][DW-1:0]    dev_wdata, dev_rdata;

   int n_chk  = 0;
   int n_pass = 0;

   bus_xbar_nm #(
      .NrHosts(NH), .NrDevices(ND), .AW(AW), .DW(DW),
      .DevOutstanding(2), .AddrBase(BASE), .AddrMask(MASK)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .host_req_i(host_req), .host_addr_i(host_addr), .host_we_i(host_we),
      .host_be_i(host_be), .host_wdata_i(host_wdata),
      .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid),
      .host_rdata_o(host_rdata), .host_err_o(host_err),
      .dev_req_o(dev_req), .dev_addr_o(dev_addr), .dev_we_o(dev_we),
      .dev_be_o(dev_be), .dev_wdata_o(dev_wdata),
      .dev_gnt_i(dev_gnt), .dev_rvalid_i(dev_rvalid),
      .dev_rdata_i(dev_rdata), .dev_err_i(dev_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      host_req   = '0;
      host_we    = '0;
      host_be    = '0;
      host_wdata = '0;
      dev_gnt    = '0;
      dev_rvalid = '0;
      dev_rdata  = '0;
      dev_err    = '0;
   endtask

   initial begin
      int eh;
      clr();
      host_addr = '0;
      rst_n     = 1'b0;
      // outputs held at zero during reset, even with live inputs
      host_req[0]  = 1'b1;
      host_addr[0] = 32'h0010_0010;
      dev_gnt      = '1;
      dev_rvalid   = '1;
      #1;
      check("rst_dev_req", 64'(dev_req), 64'(4'b0000));
      check("rst_host_gnt", 64'(host_gnt), 64'(3'b000));
      check("rst_host_rvalid", 64'(host_rvalid), 64'(3'b000));
      tick();
      tick();
      clr();
      rst_n = 1'b1;
      tick();

      // single read, zero added latency
      host_req[0]  = 1'b1;
      host_addr[0] = 32'h0010_0010;
      dev_gnt[0]   = 1'b1;
      #1;
      check("t1_dev_req", 64'(dev_req), 64'(4'b0001));
      check("t1_dev_addr", 64'(dev_addr[0]), 64'h0010_0010);
      check("t1_host_gnt", 64'(host_gnt), 64'(3'b001));
      tick();
      clr();
      #1;
      check("t1_no_rvalid", 64'(host_rvalid), 64'(3'b000));
      tick();
      dev_rvalid[0] = 1'b1;
      dev_rdata[0]  = 32'hDEAD_BEEF;
      #1;
      check("t1_rvalid", 64'(host_rvalid), 64'(3'b001));
      check("t1_rdata", 64'(host_rdata[0]), 64'hDEAD_BEEF);
      check("t1_err", 64'(host_err), 64'(3'b000));
      tick();
      clr();

      // write decoded to device 1
      host_req[2]   = 1'b1;
      host_addr[2]  = 32'h0002_0004;
      host_we[2]    = 1'b1;
      host_be[2]    = 4'hF;
      host_wdata[2] = 32'h0000_1234;
      dev_gnt[1]    = 1'b1;
      #1;
      check("dec_dev_req", 64'(dev_req), 64'(4'b0010));
      check("dec_we", 64'(dev_we[1]), 64'(1'b1));
      check("dec_wdata", 64'(dev_wdata[1]), 64'h1234);
      check("dec_gnt", 64'(host_gnt), 64'(3'b100));
      tick();
      clr();
      dev_rvalid[1] = 1'b1;
      #1;
      check("dec_rvalid", 64'(host_rvalid), 64'(3'b100));
      tick();
      clr();

      // two hosts streaming; dev0 pointer sits at 1 after the first read
      host_addr[0] = 32'h0010_0020;
      host_addr[1] = 32'h0010_0040;
      for (int i = 0; i < 5; i++) begin
         host_req      = (i < 4) ? 3'b011 : 3'b000;
         dev_gnt[0]    = (i < 4);
         dev_rvalid[0] = (i > 0);
         dev_rdata[0]  = 32'(32'hA0 + i - 1);
         #1;
         if (i < 4)
            check("rr_gnt", 64'(host_gnt), (i % 2 == 0) ? 64'(3'b010) : 64'(3'b001));
         if (i > 0) begin
            eh = ((i - 1) % 2 == 0) ? 1 : 0;
            check("rr_rvalid", 64'(host_rvalid), 64'(3'b001 << eh));
            check("rr_rdata", 64'(host_rdata[eh]), 64'(32'hA0 + i - 1));
         end
         tick();
      end
      clr();

      // stalled winner is held
      host_addr[0] = 32'h0010_0100;
      host_addr[1] = 32'h0010_0200;
      host_req     = 3'b001;
      #1;
      check("st_req0", 64'(dev_req), 64'(4'b0001));
      check("st_gnt0", 64'(host_gnt), 64'(3'b000));
      tick();
      for (int i = 1; i < 5; i++) begin
         host_req = 3'b011;
         #1;
         check("st_req", 64'(dev_req[0]), 64'(1'b1));
         check("st_addr", 64'(dev_addr[0]), 64'h0010_0100);
         check("st_gnt", 64'(host_gnt), 64'(3'b000));
         tick();
      end
      dev_gnt[0] = 1'b1;
      #1;
      check("st_rel_gnt", 64'(host_gnt), 64'(3'b001));
      tick();
      host_req      = 3'b010;
      dev_rvalid[0] = 1'b1;
      dev_rdata[0]  = 32'hB0;
      #1;
      check("st_h1_gnt", 64'(host_gnt), 64'(3'b010));
      check("st_h1_addr", 64'(dev_addr[0]), 64'h0010_0200);
      check("st_h0_rvalid", 64'(host_rvalid), 64'(3'b001));
      check("st_h0_rdata", 64'(host_rdata[0]), 64'hB0);
      tick();
      clr();
      dev_rvalid[0] = 1'b1;
      dev_rdata[0]  = 32'hB1;
      #1;
      check("st_h1_rvalid", 64'(host_rvalid), 64'(3'b010));
      check("st_h1_rdata", 64'(host_rdata[1]), 64'hB1);
      tick();
      clr();

      // unmapped access alongside a RAM access
      host_addr[0] = 32'h9000_0000;
      host_addr[1] = 32'h0010_0300;
      host_req     = 3'b011;
      dev_gnt[0]   = 1'b1;
      #1;
      check("um_gnt", 64'(host_gnt), 64'(3'b011));
      check("um_dev_req", 64'(dev_req), 64'(4'b0001));
      check("um_dev_addr", 64'(dev_addr[0]), 64'h0010_0300);
      check("um_no_rvalid", 64'(host_rvalid), 64'(3'b000));
      tick();
      clr();
      dev_rvalid[0] = 1'b1;
      dev_rdata[0]  = 32'h55;
      #1;
      check("um_rvalid", 64'(host_rvalid), 64'(3'b011));
      check("um_err", 64'(host_err), 64'(3'b001));
      check("um_rdata0", 64'(host_rdata[0]), 64'h0);
      check("um_rdata1", 64'(host_rdata[1]), 64'h55);
      tick();
      clr();
      #1;
      check("um_once", 64'(host_rvalid), 64'(3'b000));
      tick();

      // FIFO full back-pressure
      host_addr[0] = 32'h0010_0400;
      host_addr[1] = 32'h0010_0500;
      host_addr[2] = 32'h0010_0600;
      host_req     = 3'b111;
      dev_gnt[0]   = 1'b1;
      #1;
      check("ff_gnt_h2", 64'(host_gnt), 64'(3'b100));
      tick();
      host_req = 3'b011;
      #1;
      check("ff_gnt_h0", 64'(host_gnt), 64'(3'b001));
      tick();
      for (int i = 0; i < 2; i++) begin
         host_req = 3'b010;
         #1;
         check("ff_full_req", 64'(dev_req), 64'(4'b0000));
         check("ff_full_gnt", 64'(host_gnt), 64'(3'b000));
         tick();
      end
      dev_rvalid[0] = 1'b1;
      dev_rdata[0]  = 32'h77;
      #1;
      check("ff_resume_req", 64'(dev_req), 64'(4'b0001));
      check("ff_resume_gnt", 64'(host_gnt), 64'(3'b010));
      check("ff_rvalid_h2", 64'(host_rvalid), 64'(3'b100));
      check("ff_rdata_h2", 64'(host_rdata[2]), 64'h77);
      tick();
      clr();
      dev_rvalid[0] = 1'b1;
      dev_rdata[0]  = 32'h78;
      #1;
      check("ff_rvalid_h0", 64'(host_rvalid), 64'(3'b001));
      check("ff_rdata_h0", 64'(host_rdata[0]), 64'h78);
      tick();
      dev_rdata[0] = 32'h79;
      #1;
      check("ff_rvalid_h1", 64'(host_rvalid), 64'(3'b010));
      check("ff_rdata_h1", 64'(host_rdata[1]), 64'h79);
      tick();
      clr();

      // reset with two outstanding
      host_addr[0] = 32'h0010_0700;
      host_addr[1] = 32'h0010_0800;
      host_req     = 3'b011;
      dev_gnt[0]   = 1'b1;
      #1;
      check("rs_gnt_h0", 64'(host_gnt), 64'(3'b001));
      tick();
      host_req = 3'b010;
      #1;
      check("rs_gnt_h1", 64'(host_gnt), 64'(3'b010));
      tick();
      rst_n         = 1'b0;
      host_req      = 3'b011;
      dev_rvalid[0] = 1'b1;
      #1;
      check("rs_in_rvalid", 64'(host_rvalid), 64'(3'b000));
      check("rs_in_gnt", 64'(host_gnt), 64'(3'b000));
      check("rs_in_req", 64'(dev_req), 64'(4'b0000));
      tick();
      rst_n = 1'b1;
      clr();
      dev_rvalid[0] = 1'b1;
      dev_rdata[0]  = 32'hCC;
      #1;
      check("rs_late_drop", 64'(host_rvalid), 64'(3'b000));
      tick();
      clr();
      host_req   = 3'b011;
      dev_gnt[0] = 1'b1;
      #1;
      check("rs_first_gnt", 64'(host_gnt), 64'(3'b001));
      tick();
      clr();
      dev_rvalid[0] = 1'b1;
      dev_rdata[0]  = 32'hCD;
      #1;
      check("rs_rvalid", 64'(host_rvalid), 64'(3'b001));
      tick();
      clr();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
